// File: rtl/cache_ctrl.sv
// Sequencer for one direct-mapped, one-word-per-line cache group: hit check and hit
// writes, dirty victim write-back and refill from memory, plus hit/miss counters.
module cache_ctrl #(
  parameter int ADDR_W = 32,
  parameter int IDX_W  = 6,
  parameter int CNT_W  = 32,
  localparam int TAG_W = ADDR_W - IDX_W - 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [1:0]        cpu_size,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_ack,
  output logic [31:0]       cpu_rdata,
  output logic [ADDR_W-1:0] g_addr,
  output logic [1:0]        g_size,
  output logic              g_we,
  output logic              g_wp,
  output logic              g_wm,
  output logic              g_wd,
  output logic              g_rep,
  output logic [31:0]       g_data_w,
  input  logic              g_hit,
  input  logic              g_need_r,
  input  logic [TAG_W-1:0]  g_ctag_r,
  input  logic [31:0]       g_data_r,
  input  logic [31:0]       g_data_s,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt,
  output logic [2:0]        state_dbg
);

  // Handshakes: cpu_req and its payload are held by the CPU until the one-cycle
  // cpu_ack; mem_req and its payload are held here until the one-cycle mem_ack,
  // and mem_req drops the cycle after. mem_ack without mem_req is ignored.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_WB     = 3'd2,
    S_FILL   = 3'd3,
    S_REFILL = 3'd4
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   addr_q;
  logic [1:0]          size_q;
  logic                wr_q;
  logic [31:0]         wdata_q;
  logic [31:0]         fill_q;
  logic                revisit_q;
  logic [IDX_W-1:0]    idx;
  logic [TAG_W-1:0]    tag;

  assign idx       = addr_q[IDX_W+1:2];
  assign tag       = addr_q[ADDR_W-1:IDX_W+2];
  assign g_addr    = addr_q;
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      addr_q    <= '0;
      size_q    <= '0;
      wr_q      <= 1'b0;
      wdata_q   <= '0;
      fill_q    <= '0;
      revisit_q <= 1'b0;
      mem_req   <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cpu_req) begin
            addr_q  <= cpu_addr;
            size_q  <= cpu_size;
            wr_q    <= cpu_wr;
            wdata_q <= cpu_wdata;
            state   <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          revisit_q <= 1'b0;
          if (g_hit) begin
            // The lookup after a refill finishes a request already counted as a miss.
            if (!revisit_q) hit_cnt <= hit_cnt + CNT_W'(1);
            state <= S_IDLE;
          end else begin
            miss_cnt <= miss_cnt + CNT_W'(1);
            mem_req  <= 1'b1;
            if (g_need_r) begin
              mem_wr    <= 1'b1;
              mem_addr  <= {g_ctag_r, idx, 2'b00};
              mem_wdata <= g_data_r;
              state     <= S_WB;
            end else begin
              mem_wr   <= 1'b0;
              mem_addr <= {tag, idx, 2'b00};
              state    <= S_FILL;
            end
          end
        end
        S_WB: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_wr  <= 1'b0;
            state   <= S_FILL;
          end
        end
        S_FILL: begin
          // Entered from WB with mem_req low: raise the fill read one cycle later.
          if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_wr   <= 1'b0;
            mem_addr <= {tag, idx, 2'b00};
          end else if (mem_ack) begin
            mem_req <= 1'b0;
            fill_q  <= mem_rdata;
            state   <= S_REFILL;
          end
        end
        S_REFILL: begin
          revisit_q <= 1'b1;
          state     <= S_LOOKUP;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    cpu_ack   = 1'b0;
    cpu_rdata = '0;
    g_size    = size_q;
    g_we      = 1'b0;
    g_wp      = 1'b0;
    g_wm      = 1'b0;
    g_wd      = 1'b0;
    g_rep     = 1'b0;
    g_data_w  = wdata_q;
    case (state)
      S_LOOKUP: begin
        if (g_hit) begin
          cpu_ack   = 1'b1;
          cpu_rdata = g_data_s;
          if (wr_q) begin
            g_we = 1'b1;
            g_wd = 1'b1;
          end
        end
      end
      S_REFILL: begin
        g_we     = 1'b1;
        g_wp     = 1'b1;
        g_rep    = 1'b1;
        g_wm     = 1'b1;
        g_size   = 2'b10;
        g_data_w = fill_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// Bench for cache_ctrl: behavioural cache group and memory around the DUT, directed
// vector table, reset/stray-ack sequences, and randomized accesses against a flat-memory model.
module tb_cache_ctrl;
  logic        clk, rst;
  logic        cpu_req, cpu_wr;
  logic [1:0]  cpu_size;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        cpu_ack;
  logic [31:0] cpu_rdata;
  logic [31:0] g_addr;
  logic [1:0]  g_size;
  logic        g_we, g_wp, g_wm, g_wd, g_rep;
  logic [31:0] g_data_w;
  logic        g_hit, g_need_r;
  logic [23:0] g_ctag_r;
  logic [31:0] g_data_r, g_data_s;
  logic        mem_req, mem_wr, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] hit_cnt, miss_cnt;
  logic [2:0]  state_dbg;

  cache_ctrl #(.ADDR_W(32), .IDX_W(6), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_size(cpu_size), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .g_addr(g_addr), .g_size(g_size), .g_we(g_we), .g_wp(g_wp), .g_wm(g_wm), .g_wd(g_wd),
    .g_rep(g_rep), .g_data_w(g_data_w), .g_hit(g_hit), .g_need_r(g_need_r),
    .g_ctag_r(g_ctag_r), .g_data_r(g_data_r), .g_data_s(g_data_s),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // behavioural cache group (tag/data/valid/dirty, one way)
  logic        env_clr;
  logic [23:0] gtag  [64];
  logic [31:0] gdata [64];
  logic        gval  [64];
  logic        gdirty[64];
  logic [31:0] env_nw;

  always_comb begin
    g_hit    = gval[g_addr[7:2]] && (gtag[g_addr[7:2]] == g_addr[31:8]);
    g_need_r = gval[g_addr[7:2]] && gdirty[g_addr[7:2]];
    g_ctag_r = gtag[g_addr[7:2]];
    g_data_r = gdata[g_addr[7:2]];
    g_data_s = gdata[g_addr[7:2]] >> {g_addr[1:0], 3'b000};
  end

  always_comb begin
    env_nw = gdata[g_addr[7:2]];
    if (g_wm) env_nw = g_data_w;
    else begin
      case (g_size)
        2'b00:   env_nw[{g_addr[1:0], 3'b000} +: 8] = g_data_w[7:0];
        2'b01:   env_nw[{g_addr[1], 4'b0000} +: 16] = g_data_w[15:0];
        default: env_nw = g_data_w;
      endcase
    end
  end

  always @(posedge clk) begin
    if (env_clr) begin
      for (int i = 0; i < 64; i++) begin
        gval[i] <= 1'b0; gdirty[i] <= 1'b0; gtag[i] <= '0; gdata[i] <= '0;
      end
    end else if (g_we) begin
      gdata[g_addr[7:2]]  <= env_nw;
      gdirty[g_addr[7:2]] <= g_wd;
      if (g_wp && g_rep) begin
        gtag[g_addr[7:2]] <= g_addr[31:8];
        gval[g_addr[7:2]] <= 1'b1;
      end
    end
  end

  // backing memory and its responder
  logic [31:0] seed_mem [logic [31:0]];
  logic [31:0] wb_mem   [logic [31:0]];
  logic [31:0] wb_log_a[$], wb_log_d[$], rd_log_a[$];
  int mem_delay, stray_n;
  int busy, stray_done, stray_left;

  function automatic logic [31:0] base_word(input logic [31:0] wa);
    if (seed_mem.exists(wa)) return seed_mem[wa];
    return wa * 32'h9E3779B1 ^ 32'h5A5A5A5A;
  endfunction

  function automatic logic [31:0] mem_read(input logic [31:0] wa);
    if (wb_mem.exists(wa)) return wb_mem[wa];
    return base_word(wa);
  endfunction

  initial begin
    mem_ack = 1'b0; mem_rdata = '0; busy = 0; stray_done = 0; stray_left = 0;
    forever begin
      @(posedge clk); #1;
      if (stray_done != stray_n) begin
        stray_done = stray_n;
        stray_left = 2;
      end
      if (stray_left > 0) begin
        mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0; stray_left--;
      end else if (mem_ack) begin
        mem_ack = 1'b0; busy = 0;
      end else if (mem_req && rst) begin
        if (busy >= mem_delay) begin
          mem_ack = 1'b1; busy = 0;
          if (mem_wr) begin
            wb_mem[mem_addr] = mem_wdata;
            wb_log_a.push_back(mem_addr);
            wb_log_d.push_back(mem_wdata);
          end else begin
            mem_rdata = mem_read(mem_addr);
            rd_log_a.push_back(mem_addr);
          end
        end else busy++;
      end else busy = 0;
    end
  end

  // reference model: flat memory plus which tag each index holds
  logic [31:0] ref_mem [logic [31:0]];
  logic        res_val[64], res_dirty[64];
  logic [23:0] res_tag[64];
  int          ref_hits, ref_misses;
  logic [63:0] exp_q[$];

  function automatic logic [31:0] ref_read(input logic [31:0] wa);
    if (ref_mem.exists(wa)) return ref_mem[wa];
    return base_word(wa);
  endfunction

  task automatic ref_access(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                            input logic [31:0] wdata, output logic hit, output logic wb,
                            output logic [31:0] wb_addr, output logic [31:0] wb_data,
                            output logic [31:0] rdata);
    int ix;
    logic [31:0] w, wa;
    ix = int'(addr[7:2]);
    wa = {addr[31:2], 2'b00};
    hit = res_val[ix] && (res_tag[ix] == addr[31:8]);
    wb = 1'b0; wb_addr = '0; wb_data = '0;
    if (hit) ref_hits++;
    else begin
      ref_misses++;
      if (res_val[ix] && res_dirty[ix]) begin
        wb = 1'b1;
        wb_addr = {res_tag[ix], addr[7:2], 2'b00};
        wb_data = ref_read(wb_addr);
        exp_q.push_back({wb_addr, wb_data});
      end
      res_val[ix] = 1'b1; res_tag[ix] = addr[31:8]; res_dirty[ix] = 1'b0;
    end
    w = ref_read(wa);
    rdata = w >> {addr[1:0], 3'b000};
    if (wr) begin
      case (size)
        2'b00:   w[{addr[1:0], 3'b000} +: 8] = wdata[7:0];
        2'b01:   w[{addr[1], 4'b0000} +: 16] = wdata[15:0];
        default: w = wdata;
      endcase
      ref_mem[wa] = w;
      res_dirty[ix] = 1'b1;
    end
  endtask

  // scoreboard
  int checks, errors;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver
  task automatic do_access(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                           input logic [31:0] wdata, output logic [31:0] rdata,
                           output int lat, output int acks);
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_wr = wr; cpu_size = size; cpu_addr = addr; cpu_wdata = wdata;
    lat = 0; acks = 0; rdata = '0;
    while (acks == 0 && lat < 100) begin
      @(negedge clk); lat++;
      if (cpu_ack) begin acks = 1; rdata = cpu_rdata; end
    end
    @(posedge clk); #1;
    cpu_req = 1'b0;
    @(negedge clk);
    if (cpu_ack) acks++;
    lat = lat - 1;
  endtask

  task automatic check_access(input string nm, input logic wr, input logic [1:0] size,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp_rdata, input int exp_lat, input int exp_rd,
                              input int exp_wb, input logic [31:0] exp_wb_addr,
                              input logic [31:0] exp_wb_data, input int exp_hits, input int exp_misses);
    int nwb, nrd, lat, acks;
    logic [31:0] rd;
    nwb = wb_log_a.size(); nrd = rd_log_a.size();
    do_access(wr, size, addr, wdata, rd, lat, acks);
    chk({nm, "_ack_count"}, 64'(acks), 64'(1));
    chk({nm, "_latency"}, 64'(lat), 64'(exp_lat));
    if (!wr) chk({nm, "_rdata"}, 64'(rd), 64'(exp_rdata));
    chk({nm, "_hit_cnt"}, 64'(hit_cnt), 64'(exp_hits));
    chk({nm, "_miss_cnt"}, 64'(miss_cnt), 64'(exp_misses));
    chk({nm, "_wb_count"}, 64'(wb_log_a.size() - nwb), 64'(exp_wb));
    chk({nm, "_fill_count"}, 64'(rd_log_a.size() - nrd), 64'(exp_rd));
    if (exp_wb == 1 && wb_log_a.size() > nwb) begin
      chk({nm, "_wb_addr"}, 64'(wb_log_a[nwb]), 64'(exp_wb_addr));
      chk({nm, "_wb_data"}, 64'(wb_log_d[nwb]), 64'(exp_wb_data));
    end
    if (exp_rd == 1 && rd_log_a.size() > nrd)
      chk({nm, "_fill_addr"}, 64'(rd_log_a[nrd]), 64'({addr[31:2], 2'b00}));
  endtask

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          delay;
    logic [31:0] exp_rdata;
    int          exp_lat;
    int          exp_rd;
    int          exp_wb;
    logic [31:0] exp_wb_addr;
    logic [31:0] exp_wb_data;
    int          exp_hits;
    int          exp_misses;
  } vec_t;

  vec_t        vt[5];
  logic [23:0] tags[4];
  logic [5:0]  idxs[4];

  initial begin
    logic        hit, wb, wr;
    logic [31:0] wba, wbd, rdx, addr, wd;
    logic [1:0]  sz, off;
    int          d, bad, waited, exp_lat;

    checks = 0; errors = 0; mem_delay = 0; stray_n = 0;
    ref_hits = 0; ref_misses = 0;
    for (int i = 0; i < 64; i++) begin
      res_val[i] = 1'b0; res_dirty[i] = 1'b0; res_tag[i] = '0;
    end
    tags = '{24'h000010, 24'h000011, 24'h000020, 24'hFFFFFF};
    idxs = '{6'd0, 6'd1, 6'd2, 6'd63};
    seed_mem[32'h00001004] = 32'hDEADBEEF;
    seed_mem[32'h00002004] = 32'h12345678;

    //          wr    size   addr          wdata         d  rdata         lat rd wb wb_addr       wb_data       h  m
    vt[0] = '{1'b0, 2'b10, 32'h00001004, 32'h00000000, 3, 32'hDEADBEEF, 7, 1, 0, 32'h0,        32'h0,        0, 1};
    vt[1] = '{1'b0, 2'b10, 32'h00001004, 32'h00000000, 0, 32'hDEADBEEF, 1, 0, 0, 32'h0,        32'h0,        1, 1};
    vt[2] = '{1'b1, 2'b00, 32'h00001005, 32'h000000AA, 0, 32'h0,        1, 0, 0, 32'h0,        32'h0,        2, 1};
    vt[3] = '{1'b0, 2'b10, 32'h00001004, 32'h00000000, 0, 32'hDEADAAEF, 1, 0, 0, 32'h0,        32'h0,        3, 1};
    vt[4] = '{1'b0, 2'b10, 32'h00002004, 32'h00000000, 1, 32'h12345678, 8, 1, 1, 32'h00001004, 32'hDEADAAEF, 3, 2};

    // reset state
    rst = 1'b0; env_clr = 1'b1;
    cpu_req = 1'b0; cpu_wr = 1'b0; cpu_size = 2'b00; cpu_addr = '0; cpu_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_strobes", 64'({cpu_ack, g_we, g_wp, g_wm, g_wd, g_rep, mem_req, mem_wr}), 64'(0));
    chk("reset_addrs", 64'({g_addr, mem_addr}), 64'(0));
    chk("reset_data", 64'({mem_wdata, g_data_w}), 64'(0));
    chk("reset_rdata_size", 64'({cpu_rdata, g_size}), 64'(0));
    chk("reset_counters", {hit_cnt, miss_cnt}, 64'(0));
    chk("reset_state_idle", 64'(state_dbg), 64'(0));
    @(negedge clk);
    env_clr = 1'b0; rst = 1'b1;

    // directed vector table
    for (int i = 0; i < 5; i++) begin
      mem_delay = vt[i].delay;
      ref_access(vt[i].wr, vt[i].size, vt[i].addr, vt[i].wdata, hit, wb, wba, wbd, rdx);
      check_access($sformatf("vec%0d", i), vt[i].wr, vt[i].size, vt[i].addr, vt[i].wdata,
                   vt[i].exp_rdata, vt[i].exp_lat, vt[i].exp_rd, vt[i].exp_wb,
                   vt[i].exp_wb_addr, vt[i].exp_wb_data, vt[i].exp_hits, vt[i].exp_misses);
    end

    // stray mem_ack pulses in IDLE, then across an accepted request and its LOOKUP
    @(negedge clk);
    stray_n++;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (mem_req || cpu_ack) bad++;
    end
    chk("stray_idle_quiet", 64'(bad), 64'(0));
    chk("stray_idle_counters", {hit_cnt, miss_cnt}, {32'd3, 32'd2});
    stray_n++;
    ref_access(1'b0, 2'b10, 32'h00002004, 32'h0, hit, wb, wba, wbd, rdx);
    check_access("stray_lookup", 1'b0, 2'b10, 32'h00002004, 32'h0, 32'h12345678,
                 1, 0, 0, 32'h0, 32'h0, 4, 2);

    // asynchronous reset while the fill waits on memory
    mem_delay = 60;
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_size = 2'b10; cpu_addr = 32'h00003004; cpu_wdata = '0;
    waited = 0;
    while (!mem_req && waited < 20) begin
      @(negedge clk); waited++;
    end
    chk("rstfill_req_seen", 64'(mem_req), 64'(1));
    chk("rstfill_req_is_read", 64'({mem_wr, mem_addr}), {32'h0, 32'h00003004});
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b0; cpu_req = 1'b0;
    #1;
    chk("rstfill_req_dropped", 64'({mem_req, cpu_ack}), 64'(0));
    chk("rstfill_counters", {hit_cnt, miss_cnt}, 64'(0));
    ref_hits = 0; ref_misses = 0;
    @(negedge clk);
    rst = 1'b1;
    stray_n++;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (mem_req || cpu_ack) bad++;
    end
    chk("rstfill_late_ack_ignored", 64'(bad), 64'(0));
    chk("rstfill_counters_after", {hit_cnt, miss_cnt}, 64'(0));

    // randomized accesses against the reference model
    for (int n = 0; n < 150; n++) begin
      sz = 2'($urandom_range(0, 2));
      case (sz)
        2'b00:   off = 2'($urandom_range(0, 3));
        2'b01:   off = {1'($urandom_range(0, 1)), 1'b0};
        default: off = 2'b00;
      endcase
      addr = {tags[$urandom_range(0, 3)], idxs[$urandom_range(0, 3)], off};
      wr = 1'($urandom_range(0, 1));
      wd = $urandom;
      d = $urandom_range(0, 3);
      mem_delay = d;
      ref_access(wr, sz, addr, wd, hit, wb, wba, wbd, rdx);
      exp_lat = hit ? 1 : (wb ? 6 + 2 * d : 4 + d);
      check_access("rnd", wr, sz, addr, wd, rdx, exp_lat, hit ? 0 : 1, wb ? 1 : 0,
                   wba, wbd, ref_hits, ref_misses);
    end

    // every predicted write-back, in order
    chk("wb_total", 64'(wb_log_a.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < wb_log_a.size(); i++)
      chk($sformatf("wb_seq%0d", i), {wb_log_a[i], wb_log_d[i]}, exp_q[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
